ibex_multdiv_iter: RTL and testbench

Parametrised iterative multiply/divide unit for the Ibex execution stage, the generalised successor to the fixed 32-bit multdiv path. It is decoupled from the ALU by a valid/ready request/response handshake and computes RV32M-style MUL/MULH/DIV/REM at any operand width. It offers optional early-out on trivial divides and multiplies, which is disabled under data-independent timing. A kill input lets the ID stage abandon an operation on flush.

---
 rtl/ibex_multdiv_iter.sv | 196 +++++++++++++++++++
 tb/tb_ibex_multdiv_iter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_multdiv_iter.sv
// Iterative RV32M-style multiply/divide unit with a valid/ready request/response handshake.
// It uses radix-2 shift-add multiply and restoring divide, with optional early-out on trivial operands.
//
// state | meaning
// IDLE  | waiting for a request
// CALC  | Width shift-add / shift-subtract iterations
// FIX   | sign correction and result register load
// DONE  | response valid, holding until rsp_ready_i
module ibex_multdiv_iter #(
  parameter int Width    = 32,
  parameter bit EarlyOut = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       op_i,
  input  logic [1:0]       signed_mode_i,
  input  logic [Width-1:0] operand_a_i,
  input  logic [Width-1:0] operand_b_i,
  input  logic             data_ind_timing_i,
  input  logic             kill_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [Width-1:0] result_o,
  output logic             busy_o
);

  localparam int CntW = $clog2(Width) + 1;
  localparam logic [CntW-1:0] LastIter = CntW'(Width - 1);
  localparam logic [Width-1:0] MinNeg = {1'b1, {(Width-1){1'b0}}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] OP_MULL = 2'd0;
  localparam logic [1:0] OP_MULH = 2'd1;
  localparam logic [1:0] OP_DIV  = 2'd2;
  localparam logic [1:0] OP_REM  = 2'd3;

  logic [1:0]       r_state;
  logic [CntW-1:0]  r_cnt;
  logic [1:0]       r_op;
  logic             r_a_neg;
  logic             r_b_neg;
  logic             r_b_zero;
  logic [Width:0]   r_a_mag;
  logic [Width:0]   r_b_mag;
  logic [Width:0]   r_hi;
  logic [Width-1:0] r_lo;
  logic [Width-1:0] r_result;

  logic             w_accept;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [Width:0]   w_a_mag;
  logic [Width:0]   w_b_mag;
  logic             w_a_zero;
  logic             w_b_zero;
  logic             w_ovf;
  logic             w_early;
  logic [Width-1:0] w_early_res;

  assign req_ready_o = rst_ni & (r_state == IDLE) & ~kill_i;
  assign w_accept    = req_valid_i & req_ready_o;

  // Width+1 bit magnitudes keep the most-negative operand representable
  assign w_a_neg = signed_mode_i[0] & operand_a_i[Width-1];
  assign w_b_neg = signed_mode_i[1] & operand_b_i[Width-1];
  assign w_a_mag = w_a_neg ? -{1'b1, operand_a_i} : {1'b0, operand_a_i};
  assign w_b_mag = w_b_neg ? -{1'b1, operand_b_i} : {1'b0, operand_b_i};

  assign w_a_zero = (operand_a_i == '0);
  assign w_b_zero = (operand_b_i == '0);
  assign w_ovf    = op_i[1] & (signed_mode_i == 2'b11) & (operand_a_i == MinNeg) &
                    (operand_b_i == '1);
  assign w_early  = EarlyOut & ~data_ind_timing_i &
                    (op_i[1] ? (w_b_zero | w_ovf) : (w_a_zero | w_b_zero));

  always_comb begin
    w_early_res = '0;
    if (op_i[1]) begin
      if (w_b_zero) begin
        w_early_res = op_i[0] ? operand_a_i : '1;
      end else begin
        w_early_res = op_i[0] ? '0 : operand_a_i;
      end
    end
  end

  logic [Width:0]   w_sum;
  logic [Width:0]   w_mul_sel;
  logic [Width:0]   w_shift;
  logic [Width+1:0] w_diff;
  logic             w_ge;

  assign w_sum     = r_hi + r_a_mag;
  assign w_mul_sel = r_lo[0] ? w_sum : r_hi;
  assign w_shift   = {r_hi[Width-1:0], r_lo[Width-1]};
  assign w_diff    = {1'b0, w_shift} - {1'b0, r_b_mag};
  assign w_ge      = ~w_diff[Width+1];

  logic [2*Width-1:0] w_prod;
  logic [2*Width-1:0] w_prod_fix;
  logic [Width-1:0]   w_quo_fix;
  logic [Width-1:0]   w_rem_fix;
  logic [Width-1:0]   w_fix_res;

  // Quotient stays all-ones on divide-by-zero regardless of operand signs
  assign w_prod     = {r_hi[Width-1:0], r_lo};
  assign w_prod_fix = (r_a_neg ^ r_b_neg) ? -w_prod : w_prod;
  assign w_quo_fix  = ((r_a_neg ^ r_b_neg) & ~r_b_zero) ? -r_lo : r_lo;
  assign w_rem_fix  = r_a_neg ? -r_hi[Width-1:0] : r_hi[Width-1:0];

  always_comb begin
    w_fix_res = '0;
    case (r_op)
      OP_MULL: w_fix_res = w_prod_fix[Width-1:0];
      OP_MULH: w_fix_res = w_prod_fix[2*Width-1:Width];
      OP_DIV:  w_fix_res = w_quo_fix;
      OP_REM:  w_fix_res = w_rem_fix;
      default: w_fix_res = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_b_zero <= 1'b0;
      r_a_mag  <= '0;
      r_b_mag  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
    end else if (kill_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op     <= op_i;
            r_a_neg  <= w_a_neg;
            r_b_neg  <= w_b_neg;
            r_b_zero <= w_b_zero;
            r_a_mag  <= w_a_mag;
            r_b_mag  <= w_b_mag;
            r_hi     <= '0;
            r_lo     <= op_i[1] ? w_a_mag[Width-1:0] : w_b_mag[Width-1:0];
            r_cnt    <= '0;
            if (w_early) begin
              r_result <= w_early_res;
              r_state  <= DONE;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          if (r_op[1]) begin
            r_hi <= w_ge ? w_diff[Width:0] : w_shift;
            r_lo <= {r_lo[Width-2:0], w_ge};
          end else begin
            r_hi <= {1'b0, w_mul_sel[Width:1]};
            r_lo <= {w_mul_sel[0], r_lo[Width-1:1]};
          end
          r_cnt <= r_cnt + CntW'(1);
          if (r_cnt == LastIter) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_result <= w_fix_res;
          r_state  <= DONE;
        end
        DONE: begin
          if (rsp_ready_i) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid_o = (r_state == DONE);
  assign busy_o      = (r_state != IDLE);
  assign result_o    = r_result;

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Self-checking bench for ibex_multdiv_iter at Width 8, 32 and 64.
// Vector table with a scoreboard queue, plus hand sequences for kill, stall and reset.
module tb_ibex_multdiv_iter;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        kill;
  logic        rsp_ready;
  logic [1:0]  op;
  logic [1:0]  sm;
  logic [63:0] a;
  logic [63:0] b;
  logic        dit;
  int          sel;

  logic        v8, v32, v64, k8, k32, k64;
  logic        rdy8, rdy32, rdy64;
  logic        val8, val32, val64;
  logic        busy8, busy32, busy64;
  logic [7:0]  res8;
  logic [31:0] res32;
  logic [63:0] res64;

  logic        sel_ready, sel_valid, sel_busy;
  logic [63:0] sel_res;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    string       name;
    int          sel;
    logic [1:0]  op;
    logic [1:0]  sm;
    logic [63:0] a;
    logic [63:0] b;
    logic        dit;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [63:0] res;
    int          lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  assign v8  = req && (sel == 0);
  assign v32 = req && (sel == 1);
  assign v64 = req && (sel == 2);
  assign k8  = kill && (sel == 0);
  assign k32 = kill && (sel == 1);
  assign k64 = kill && (sel == 2);

  ibex_multdiv_iter #(.Width(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v8), .req_ready_o(rdy8),
    .op_i(op), .signed_mode_i(sm), .operand_a_i(a[7:0]), .operand_b_i(b[7:0]),
    .data_ind_timing_i(dit), .kill_i(k8), .rsp_valid_o(val8), .rsp_ready_i(rsp_ready),
    .result_o(res8), .busy_o(busy8)
  );

  ibex_multdiv_iter #(.Width(32)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v32), .req_ready_o(rdy32),
    .op_i(op), .signed_mode_i(sm), .operand_a_i(a[31:0]), .operand_b_i(b[31:0]),
    .data_ind_timing_i(dit), .kill_i(k32), .rsp_valid_o(val32), .rsp_ready_i(rsp_ready),
    .result_o(res32), .busy_o(busy32)
  );

  ibex_multdiv_iter #(.Width(64)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v64), .req_ready_o(rdy64),
    .op_i(op), .signed_mode_i(sm), .operand_a_i(a), .operand_b_i(b),
    .data_ind_timing_i(dit), .kill_i(k64), .rsp_valid_o(val64), .rsp_ready_i(rsp_ready),
    .result_o(res64), .busy_o(busy64)
  );

  always_comb begin
    sel_ready = rdy32;
    sel_valid = val32;
    sel_busy  = busy32;
    sel_res   = {32'b0, res32};
    case (sel)
      0: begin
        sel_ready = rdy8;
        sel_valid = val8;
        sel_busy  = busy8;
        sel_res   = {56'b0, res8};
      end
      2: begin
        sel_ready = rdy64;
        sel_valid = val64;
        sel_busy  = busy64;
        sel_res   = res64;
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%h expected 0x%h", n, act, exp);
    end
  endtask

  function automatic int width_of(input int s);
    return (s == 0) ? 8 : (s == 2) ? 64 : 32;
  endfunction

  function automatic void add(input string n, input int s, input logic [1:0] o,
                              input logic [1:0] m, input logic [63:0] x, input logic [63:0] y,
                              input logic d, input logic [63:0] e, input bit early);
    vec_t v;
    v.name = n; v.sel = s; v.op = o; v.sm = m; v.a = x; v.b = y; v.dit = d; v.exp = e;
    v.lat  = early ? 1 : width_of(s) + 2;
    vecs.push_back(v);
  endfunction

  task automatic drive_and_wait(input vec_t v);
    exp_t e;
    int   lat;
    @(negedge clk);
    sel = v.sel; op = v.op; sm = v.sm; a = v.a; b = v.b; dit = v.dit; req = 1'b1;
    #1;
    check({v.name, " req_ready"}, 64'(sel_ready), 64'd1);
    e.name = v.name; e.res = v.exp; e.lat = v.lat;
    sb.push_back(e);
    lat = 0;
    do begin
      @(negedge clk);
      req = 1'b0;
      lat++;
    end while (!sel_valid && lat < 300);
    e = sb.pop_front();
    check({e.name, " latency"}, 64'(lat), 64'(e.lat));
    check({e.name, " result"}, sel_res, e.res);
  endtask

  initial begin
    vec_t v;
    int   pulses;
    int   bad;
    logic [63:0] held;

    add("mulh_s_w32",   1, 2'd1, 2'b11, 64'h8000_0000, 64'h8000_0000, 1'b0, 64'h4000_0000, 0);
    add("mull_s_w32",   1, 2'd0, 2'b11, 64'h8000_0000, 64'h8000_0000, 1'b0, 64'h0, 0);
    add("div_s_w32",    1, 2'd2, 2'b11, 64'hFFFF_FFF9, 64'h2, 1'b0, 64'hFFFF_FFFD, 0);
    add("rem_s_w32",    1, 2'd3, 2'b11, 64'hFFFF_FFF9, 64'h2, 1'b0, 64'hFFFF_FFFF, 0);
    add("divu_z_eo",    1, 2'd2, 2'b00, 64'h1234_5678, 64'h0, 1'b0, 64'hFFFF_FFFF, 1);
    add("divu_z_dit",   1, 2'd2, 2'b00, 64'h1234_5678, 64'h0, 1'b1, 64'hFFFF_FFFF, 0);
    add("remu_z_eo",    1, 2'd3, 2'b00, 64'h1234_5678, 64'h0, 1'b0, 64'h1234_5678, 1);
    add("remu_z_dit",   1, 2'd3, 2'b00, 64'h1234_5678, 64'h0, 1'b1, 64'h1234_5678, 0);
    add("div_ovf_eo",   1, 2'd2, 2'b11, 64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 64'h8000_0000, 1);
    add("rem_ovf_eo",   1, 2'd3, 2'b11, 64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 64'h0, 1);
    add("div_ovf_dit",  1, 2'd2, 2'b11, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 64'h8000_0000, 0);
    add("rem_ovf_dit",  1, 2'd3, 2'b11, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 64'h0, 0);
    add("div_s_z_dit",  1, 2'd2, 2'b11, 64'hFFFF_FFF9, 64'h0, 1'b1, 64'hFFFF_FFFF, 0);
    add("rem_s_z_dit",  1, 2'd3, 2'b11, 64'hFFFF_FFF9, 64'h0, 1'b1, 64'hFFFF_FFF9, 0);
    add("mulh_zero_eo", 1, 2'd1, 2'b11, 64'h0, 64'h1234_5678, 1'b0, 64'h0, 1);
    add("mull_zero_dit",1, 2'd0, 2'b00, 64'h1234_5678, 64'h0, 1'b1, 64'h0, 0);
    add("mulhu_max",    1, 2'd1, 2'b00, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE, 0);
    add("mulhsu_neg",   1, 2'd1, 2'b01, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFF, 0);
    add("mull_neg_s",   1, 2'd0, 2'b11, 64'hFFFF_FFFD, 64'h5, 1'b0, 64'hFFFF_FFF1, 0);
    add("mull_neg_u",   1, 2'd0, 2'b00, 64'hFFFF_FFFD, 64'h5, 1'b0, 64'hFFFF_FFF1, 0);
    add("div_mix01",    1, 2'd2, 2'b01, 64'hFFFF_FFF9, 64'h2, 1'b0, 64'hFFFF_FFFD, 0);
    add("div_mix10",    1, 2'd2, 2'b10, 64'hFFFF_FFF9, 64'h2, 1'b0, 64'h7FFF_FFFC, 0);
    add("div_mix_min",  1, 2'd2, 2'b01, 64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 64'h0, 0);
    add("rem_mix_min",  1, 2'd3, 2'b01, 64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 64'h8000_0000, 0);
    add("divu_100_7",   1, 2'd2, 2'b00, 64'd100, 64'd7, 1'b0, 64'd14, 0);
    add("remu_100_7",   1, 2'd3, 2'b00, 64'd100, 64'd7, 1'b0, 64'd2, 0);
    add("div_pos_neg",  1, 2'd2, 2'b11, 64'd7, 64'hFFFF_FFFE, 1'b0, 64'hFFFF_FFFD, 0);
    add("rem_pos_neg",  1, 2'd3, 2'b11, 64'd7, 64'hFFFF_FFFE, 1'b0, 64'h1, 0);
    add("mulh_s_w8",    0, 2'd1, 2'b11, 64'h80, 64'h80, 1'b0, 64'h40, 0);
    add("mull_s_w8",    0, 2'd0, 2'b11, 64'h80, 64'h80, 1'b0, 64'h00, 0);
    add("div_s_w8",     0, 2'd2, 2'b11, 64'hF9, 64'h02, 1'b0, 64'hFD, 0);
    add("rem_s_w8",     0, 2'd3, 2'b11, 64'hF9, 64'h02, 1'b0, 64'hFF, 0);
    add("div_ovf_w8",   0, 2'd2, 2'b11, 64'h80, 64'hFF, 1'b0, 64'h80, 1);
    add("mulh_s_w64",   2, 2'd1, 2'b11, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
        64'h4000_0000_0000_0000, 0);
    add("div_s_w64",    2, 2'd2, 2'b11, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 1'b0,
        64'hFFFF_FFFF_FFFF_FFFD, 0);
    add("rem_s_w64",    2, 2'd3, 2'b11, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 1'b0,
        64'hFFFF_FFFF_FFFF_FFFF, 0);
    add("mulhu_w64",    2, 2'd1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
        64'hFFFF_FFFF_FFFF_FFFE, 0);

    rst_n = 1'b0; req = 1'b0; kill = 1'b0; rsp_ready = 1'b1;
    op = 2'd0; sm = 2'd0; a = '0; b = '0; dit = 1'b0; sel = 1;

    repeat (3) @(negedge clk);
    check("reset rdy", {61'b0, rdy8, rdy32, rdy64}, 64'h0);
    check("reset valid", {61'b0, val8, val32, val64}, 64'h0);
    check("reset busy", {61'b0, busy8, busy32, busy64}, 64'h0);
    check("reset result32", {32'b0, res32}, 64'h0);
    check("reset result64", res64, 64'h0);
    rst_n = 1'b1;
    #1;
    check("release rdy", {61'b0, rdy8, rdy32, rdy64}, 64'h7);

    foreach (vecs[i]) begin
      v = vecs[i];
      drive_and_wait(v);
    end

    // kill in cycle 10 of a divide
    sel = 1;
    @(negedge clk);
    op = 2'd2; sm = 2'b00; a = 64'h1234_5678; b = 64'd7; dit = 1'b0; req = 1'b1;
    #1;
    check("kill accept rdy", 64'(rdy32), 64'd1);
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      req = 1'b0;
      if (val32) pulses++;
    end
    kill = 1'b1;
    #1;
    check("kill blocks rdy", 64'(rdy32), 64'd0);
    @(negedge clk);
    kill = 1'b0;
    #1;
    check("kill busy c11", 64'(busy32), 64'd0);
    check("kill rdy c11", 64'(rdy32), 64'd1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (val32) pulses++;
    end
    check("kill no rsp", 64'(pulses), 64'd0);
    v.name = "mull_after_kill"; v.sel = 1; v.op = 2'd0; v.sm = 2'b00; v.a = 64'd3; v.b = 64'd5;
    v.dit = 1'b0; v.exp = 64'd15; v.lat = 34;
    drive_and_wait(v);

    // request coinciding with kill in IDLE is dropped
    @(negedge clk);
    op = 2'd0; sm = 2'b00; a = 64'd3; b = 64'd5; req = 1'b1; kill = 1'b1;
    #1;
    check("kill idle rdy", 64'(rdy32), 64'd0);
    @(negedge clk);
    req = 1'b0; kill = 1'b0;
    check("kill idle busy", 64'(busy32), 64'd0);

    // stall in DONE then reset
    rsp_ready = 1'b0;
    v.name = "mull_stall"; v.sel = 1; v.op = 2'd0; v.sm = 2'b11; v.a = 64'hFFFF_FFFD;
    v.b = 64'd5; v.dit = 1'b0; v.exp = 64'hFFFF_FFF1; v.lat = 34;
    drive_and_wait(v);
    held = {32'b0, res32};
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!val32 || ({32'b0, res32} != held) || !busy32) bad++;
    end
    check("stall stable cycles bad", 64'(bad), 64'd0);
    check("stall result", {32'b0, res32}, 64'hFFFF_FFF1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst low rdy", 64'(rdy32), 64'd0);
    @(negedge clk);
    check("rst valid", 64'(val32), 64'd0);
    check("rst busy", 64'(busy32), 64'd0);
    check("rst result", {32'b0, res32}, 64'h0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("rst release rdy", 64'(rdy32), 64'd1);

    v.name = "mull_after_rst"; v.sel = 1; v.op = 2'd0; v.sm = 2'b00; v.a = 64'd3; v.b = 64'd5;
    v.dit = 1'b0; v.exp = 64'd15; v.lat = 34;
    drive_and_wait(v);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
